dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-only data memory: takes the EX/MEM register outputs and drives the memory's word address, write data and write strobe.
- Adds byte/halfword loads with sign or zero extension.
- Adds byte/halfword stores as a two-cycle read-modify-write, stalling the pipeline for one cycle, because the data memory has no byte enables.
- Owns the MEM/WB pipeline register.

Parameters:
- ADDR_WIDTH, 10, word-address bits driven to the data memory (byte address bits [ADDR_WIDTH+1:2]).

Ports:
- clk  in  1  pipeline clock; all registers update on the rising edge. The memory itself writes on the falling edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  EX/MEM slot holds a live instruction.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned  in  1  zero-extend loads (LBU/LHU).
- mem_addr  in  32  byte address (ALU result).
- mem_wdata  in  32  store data (rt).
- mem_rd  in  5  destination register.
- dm_addr  out  ADDR_WIDTH  word address to the data memory; combinational.
- dm_din  out  32  write data to the data memory; combinational.
- dm_wr  out  1  write strobe to the data memory; combinational.
- dm_dout  in  32  combinational read data from the data memory.
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register; combinational.
- wb_valid  out  1  registered; the MEM/WB slot is live.
- wb_rdata  out  32  registered; extended load data (0 for non-loads).
- wb_rd  out  5  registered; destination register.
- wb_load  out  1  registered; the slot is a load.
- wb_misalign  out  1  registered; misaligned-access flag (see Optional Feature).

Behaviour:
- Little-endian. byte_off = mem_addr[1:0]; dm_addr = mem_addr[ADDR_WIDTH+1:2].
- FSM states: IDLE, RMW_WR.
  - IDLE:
    - Live word store: dm_wr=1, dm_din=mem_wdata. No stall; stay in IDLE.
    - Live byte/half store: dm_wr=0, mem_stall=1. Capture dm_dout into merge_q at the rising edge, then go to RMW_WR.
    - Load: dm_wr=0, data taken from dm_dout. Stay in IDLE.
  - RMW_WR:
    - dm_wr=1. dm_din = merge_q with the selected lane replaced.
    - Byte store: byte lane byte_off gets mem_wdata[7:0].
    - Half store: lane mem_addr[1] gets mem_wdata[15:0].
    - mem_stall=0. Return to IDLE.
- Load extraction:
  - Byte = dm_dout[8*off+7 : 8*off].
  - Half = dm_dout[16*a1+15 : 16*a1], where a1 = mem_addr[1].
  - Sign-extend unless mem_unsigned=1, in which case zero-extend.
- Latency:
  - Load: wb_rdata is valid one cycle after the load is in MEM.
  - Word store: 1 cycle.
  - Sub-word store: 2 cycles; wb_valid rises after RMW_WR.
- MEM/WB register:
  - Loads when mem_stall=0, capturing valid, rd, load and extracted data.
  - When mem_stall=1, inject a bubble (wb_valid=0).
- mem_valid=0: no write, no stall, bubble to WB, FSM holds IDLE.
- mem_read and mem_write both set: store wins and the load is dropped; wb_load=0.
- Reset: FSM to IDLE, merge_q=0. wb_valid, wb_rdata, wb_rd, wb_load and wb_misalign all reset to 0.
- Reset asserted in RMW_WR: dm_wr is forced to 0 that cycle and the partial store is abandoned.
- Combinational outputs are gated by rst: while rst=1, dm_wr=0 and mem_stall=0.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined:
  - Half access with mem_addr[0]=1, or word access with mem_addr[1:0]≠0, is misaligned.
  - A misaligned store never writes: dm_wr=0, no RMW, no stall.
  - A misaligned load returns wb_rdata=0.
  - In both cases wb_misalign=1 with wb_valid=1.
- Undefined:
  - Offending low address bits are ignored: half uses mem_addr[1] only, word uses offset 0.
  - wb_misalign is tied to 0.

Test Plan:
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 -> dm_wr pulses once; wb_rdata=0xDEADBEEF one cycle after the LW; mem_stall stays 0.
- Word 0x11223344 at 0x20. SB 0xAA to 0x21, then LW 0x20 -> mem_stall=1 for exactly one cycle; memory word becomes 0x1122AA44; LW returns 0x1122AA44.
- Word 0x8001FF7F at 0x30:
  - LB 0x30 -> 0x0000007F.
  - LB 0x31 -> 0xFFFFFFFF.
  - LBU 0x31 -> 0x000000FF.
  - LH 0x32 -> 0xFFFF8001.
  - LHU 0x32 -> 0x00008001.
- SH 0xBEEF to 0x22 over 0x11223344 -> word becomes 0xBEEF3344; wb_valid stays 0 during the stall cycle.
- Assert rst during the RMW_WR cycle of an SB -> no dm_wr pulse; memory unchanged; all wb_* = 0 next cycle.
- With DM_MISALIGN_TRAP_EN: SW to 0x41 -> dm_wr=0, wb_misalign=1. Without it: SW to 0x41 writes the word at 0x40 and wb_misalign=0.

Source files
------------

// File: rtl/dm_access_unit.sv
// MEM-stage load/store unit for a word-only data memory: sub-word loads with extension,
// sub-word stores via a two-cycle read-modify-write, and the MEM/WB register.
// Optional misaligned-access trapping is enabled with `define DM_MISALIGN_TRAP_EN.
module dm_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [4:0]            mem_rd,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [31:0]           dm_din,
  output logic                  dm_wr,
  input  logic [31:0]           dm_dout,
  output logic                  mem_stall,
  output logic                  wb_valid,
  output logic [31:0]           wb_rdata,
  output logic [4:0]            wb_rd,
  output logic                  wb_load,
  output logic                  wb_misalign
);

  typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] merge_r;
  logic        is_byte_s, is_half_s, is_word_s;
  logic        do_store_s, do_load_s, misalign_s;
  logic        sub_store_s, word_store_s;
  logic        unused_s;

  // Replace the addressed byte/half lane of a word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Select the addressed lane of a read word and sign- or zero-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] dout, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = dout[{off, 3'b000} +: 8];
    h = dout[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = dout;
    endcase
    return r;
  endfunction

  assign is_byte_s  = (mem_size == 2'b00);
  assign is_half_s  = (mem_size == 2'b01);
  assign is_word_s  = ~is_byte_s & ~is_half_s;
  assign do_store_s = mem_valid & mem_write;
  assign do_load_s  = mem_valid & mem_read & ~mem_write;
`ifdef DM_MISALIGN_TRAP_EN
  assign misalign_s = (is_half_s & mem_addr[0]) | (is_word_s & (mem_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif
  assign sub_store_s  = do_store_s & ~is_word_s & ~misalign_s;
  assign word_store_s = do_store_s & is_word_s & ~misalign_s;
  assign dm_addr      = mem_addr[ADDR_WIDTH+1:2];
  assign unused_s     = ^mem_addr[31:ADDR_WIDTH+2];

  // State register and merge buffer holding the old word of a sub-word store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      merge_r <= 32'h00000000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && sub_store_s) begin
        merge_r <= dm_dout;
      end
    end
  end

  // Next-state logic: a sub-word store spends exactly one extra cycle in RMW_WR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sub_store_s) begin
          state_nxt_s = RMW_WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RMW_WR:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory-side outputs; reset suppresses any write, including an abandoned RMW.
  always_comb begin
    dm_wr     = 1'b0;
    dm_din    = mem_wdata;
    mem_stall = 1'b0;
    if (rst) begin
      dm_wr     = 1'b0;
      mem_stall = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dm_wr     = word_store_s;
          mem_stall = sub_store_s;
        end
        RMW_WR: begin
          dm_wr  = 1'b1;
          dm_din = merge_lane(merge_r, mem_wdata, mem_size, mem_addr[1:0]);
        end
        default: begin
          dm_wr     = 1'b0;
          mem_stall = 1'b0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register; a stall cycle becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst || mem_stall) begin
      wb_valid    <= 1'b0;
      wb_rdata    <= 32'h00000000;
      wb_rd       <= 5'd0;
      wb_load     <= 1'b0;
      wb_misalign <= 1'b0;
    end else begin
      wb_valid    <= mem_valid;
      wb_rd       <= mem_rd;
      wb_load     <= do_load_s;
      wb_rdata    <= (do_load_s && !misalign_s) ?
                     extract_load(dm_dout, mem_size, mem_addr[1:0], mem_unsigned) : 32'h00000000;
      wb_misalign <= misalign_s & mem_valid & (mem_read | mem_write);
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [4:0]  mem_rd;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_wr, mem_stall;
  logic        wb_valid, wb_load, wb_misalign;
  logic [31:0] wb_rdata;
  logic [4:0]  wb_rd;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int n_checks = 0;
  int n_pass   = 0;

  dm_access_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_rd(wb_rd),
    .wb_load(wb_load), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  // Word-only data memory: combinational read, falling-edge write.
  assign dm_dout = mem[dm_addr];
  always @(negedge clk) begin
    if (dm_wr) mem[dm_addr] = dm_din;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
`ifdef DM_MISALIGN_TRAP_EN
    if (sz == 2'd1) return (addr % 2) != 0;
    if (sz >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one instruction, hold it through any stall, then check WB results and memory.
  task automatic exec(input logic v, input logic rd_en, input logic wr_en, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd);
    int idx, sh, cyc, stalls, writes, exp_stalls, exp_writes;
    bit is_store, is_load, mis, st;
    logic [31:0] word, val, mask;
    idx      = int'((addr / 4) % 1024);
    word     = ref_mem[idx];
    mis      = model_misaligned(sz, addr);
    is_store = v && wr_en;
    is_load  = v && rd_en && !wr_en;
    val      = 32'd0;
    if (sz == 2'd0) begin
      sh = 8 * int'(addr % 4);  mask = 32'hFF;
    end else if (sz == 2'd1) begin
      sh = 16 * int'((addr / 2) % 2);  mask = 32'hFFFF;
    end else begin
      sh = 0;  mask = 32'hFFFFFFFF;
    end
    if (is_load && !mis) begin
      val = (word >> sh) & mask;
      if (!uns && sz == 2'd0 && val >= 32'd128)   val = val | 32'hFFFFFF00;
      if (!uns && sz == 2'd1 && val >= 32'd32768) val = val | 32'hFFFF0000;
    end
    if (is_store && !mis) ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    exp_writes = (is_store && !mis) ? 1 : 0;
    exp_stalls = (is_store && !mis && sz < 2'd2) ? 1 : 0;

    mem_valid = v; mem_read = rd_en; mem_write = wr_en; mem_size = sz;
    mem_unsigned = uns; mem_addr = addr; mem_wdata = wdata; mem_rd = rd;
    cyc = 0; stalls = 0; writes = 0;
    do begin
      @(negedge clk);
      st = mem_stall;
      if (dm_wr) writes++;
      if (st) stalls++;
      @(posedge clk); #1;
      if (st) check("bubble_valid", {31'd0, wb_valid}, 32'd0);
      cyc++;
    end while (st && cyc < 4);

    check("stall_cycles", stalls, exp_stalls);
    check("write_pulses", writes, exp_writes);
    check("wb_valid", {31'd0, wb_valid}, {31'd0, v});
    if (v) begin
      check("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      check("wb_load", {31'd0, wb_load}, {31'd0, is_load});
      check("wb_rdata", wb_rdata, val);
      check("wb_misalign", {31'd0, wb_misalign}, {31'd0, mis && (rd_en || wr_en)});
    end
    if (is_store) check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] tmp, addr;
    for (int i = 0; i < 1024; i++) begin
      tmp = $urandom();
      mem[i] = tmp;
      ref_mem[i] = tmp;
    end
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10;
    mem_unsigned = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rdata", wb_rdata, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_load", {31'd0, wb_load}, 32'd0);
    check("rst_wb_misalign", {31'd0, wb_misalign}, 32'd0);
    mem_valid = 1'b1; mem_write = 1'b1;
    @(negedge clk);
    check("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store then load.
    exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1);
    exec(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd2);
    check("lw_deadbeef", wb_rdata, 32'hDEADBEEF);

    // Byte store read-modify-write.
    exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd3);
    exec(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 5'd4);
    check("sb_mem", mem[8], 32'h1122AA44);
    exec(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd5);
    check("lw_after_sb", wb_rdata, 32'h1122AA44);

    // Sub-word loads with extension.
    exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h8001FF7F, 5'd6);
    exec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 5'd7);
    check("lb_30", wb_rdata, 32'h0000007F);
    exec(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 5'd8);
    check("lb_31", wb_rdata, 32'hFFFFFFFF);
    exec(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 5'd9);
    check("lbu_31", wb_rdata, 32'h000000FF);
    exec(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 5'd10);
    check("lh_32", wb_rdata, 32'hFFFF8001);
    exec(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 5'd11);
    check("lhu_32", wb_rdata, 32'h00008001);

    // Half store read-modify-write.
    exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd12);
    exec(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 5'd13);
    check("sh_mem", mem[8], 32'hBEEF3344);

    // Reset during the write cycle of a byte store abandons it.
    mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'b00;
    mem_addr = 32'h21; mem_wdata = 32'h00000055; mem_rd = 5'd14;
    @(negedge clk);
    check("rmw_rst_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    check("rmw_rst_no_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    check("rmw_rst_mem", mem[8], ref_mem[8]);
    check("rmw_rst_wb", {wb_valid, wb_load, wb_misalign, wb_rd, wb_rdata[23:0]}, 32'd0);
    check("rmw_rst_wb_rdata", wb_rdata, 32'd0);
    rst = 1'b0;

    // Misaligned word store and a bubble.
    exec(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'hCAFEF00D, 5'd15);
`ifndef DM_MISALIGN_TRAP_EN
    check("sw_41_mem", mem[16], 32'hCAFEF00D);
`endif
    exec(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h44, 32'h12345678, 5'd16);
    exec(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h48, 32'h0BADF00D, 5'd17);

    // Randomized traffic over a small window with junk upper address bits.
    for (int n = 0; n < 400; n++) begin
      tmp  = $urandom();
      addr = tmp & 32'hFFFFF03F;
      exec($urandom_range(0, 9) != 0, 1'($urandom()), 1'($urandom()), 2'($urandom()),
           1'($urandom()), addr, $urandom(), 5'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
